// File: rtl/rob_multiway.sv
// N-way reorder buffer: in-order dispatch and retire of up to WIDTH entries per cycle,
// CDB completion marking, single-cycle branch rollback, and a sticky halt.
module rob_multiway #(
  parameter int NUM_ROB   = 32,
  parameter int WIDTH     = 2,
  parameter int CDB_WIDTH = 2,
  parameter int PR_W      = 6,
  parameter int AR_W      = 5,
  parameter int IDX_W     = $clog2(NUM_ROB)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           dispatch_valid,
  input  logic [WIDTH*PR_W-1:0]      dispatch_T_idx,
  input  logic [WIDTH*PR_W-1:0]      dispatch_Told_idx,
  input  logic [WIDTH*AR_W-1:0]      dispatch_dest_idx,
  input  logic [WIDTH-1:0]           dispatch_halt,
  output logic [WIDTH-1:0]           dispatch_ready,
  output logic [WIDTH*IDX_W-1:0]     dispatch_ROB_idx,
  input  logic [CDB_WIDTH-1:0]       complete_valid,
  input  logic [CDB_WIDTH*IDX_W-1:0] complete_ROB_idx,
  input  logic                       rollback_en,
  input  logic [IDX_W-1:0]           rollback_idx,
  output logic [WIDTH-1:0]           retire_valid,
  output logic [WIDTH*PR_W-1:0]      retire_T_idx,
  output logic [WIDTH*PR_W-1:0]      retire_Told_idx,
  output logic [WIDTH*AR_W-1:0]      retire_dest_idx,
  output logic                       halt_out,
  output logic [IDX_W:0]             count
);

  localparam logic [IDX_W:0] ONE = (IDX_W+1)'(1);

  logic [IDX_W-1:0] head_reg;
  logic [IDX_W-1:0] tail_reg;
  logic [IDX_W:0]   count_reg;
  logic             halted_reg;

  logic            valid_reg      [NUM_ROB];
  logic            complete_reg   [NUM_ROB];
  logic            entry_halt_reg [NUM_ROB];
  logic [PR_W-1:0] t_idx_reg      [NUM_ROB];
  logic [PR_W-1:0] told_idx_reg   [NUM_ROB];
  logic [AR_W-1:0] dest_idx_reg   [NUM_ROB];

  logic [IDX_W-1:0] ret_ptr [WIDTH];
  logic [IDX_W-1:0] dsp_ptr [WIDTH];
  logic [IDX_W-1:0] cmp_idx [CDB_WIDTH];

  logic [WIDTH-1:0] accept;
  logic [IDX_W:0]   nret;
  logic [IDX_W:0]   nacc;
  logic [IDX_W:0]   free_slots;
  logic [IDX_W-1:0] rb_off;
  logic             rb_act;
  logic             ret_block;
  logic             dsp_ok;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_lane
      assign ret_ptr[gi] = head_reg + IDX_W'(gi);
      assign dsp_ptr[gi] = tail_reg + IDX_W'(gi);
      assign dispatch_ROB_idx[gi*IDX_W +: IDX_W] = dsp_ptr[gi];
      assign retire_T_idx[gi*PR_W +: PR_W]       = t_idx_reg[ret_ptr[gi]];
      assign retire_Told_idx[gi*PR_W +: PR_W]    = told_idx_reg[ret_ptr[gi]];
      assign retire_dest_idx[gi*AR_W +: AR_W]    = dest_idx_reg[ret_ptr[gi]];
    end
    for (gi = 0; gi < CDB_WIDTH; gi++) begin : g_cdb
      assign cmp_idx[gi] = complete_ROB_idx[gi*IDX_W +: IDX_W];
    end
  endgenerate

  // Distance from head to the mispredicted branch; entries further out are wrong-path.
  assign rb_off = rollback_idx - head_reg;
  assign rb_act = rollback_en & valid_reg[rollback_idx];
  assign count  = count_reg;

  always_comb begin
    retire_valid = '0;
    halt_out     = 1'b0;
    nret         = '0;
    ret_block    = ~en | halted_reg;
    for (int j = 0; j < WIDTH; j++) begin
      if (!ret_block && valid_reg[ret_ptr[j]] && complete_reg[ret_ptr[j]] &&
          !(rb_act && (IDX_W'(j) > rb_off))) begin
        retire_valid[j] = 1'b1;
        nret            = nret + ONE;
        if (entry_halt_reg[ret_ptr[j]]) begin
          halt_out  = 1'b1;
          ret_block = 1'b1;
        end
      end else begin
        ret_block = 1'b1;
      end
    end
  end

  // Slots freed by this cycle's retires are reusable by this cycle's dispatch.
  always_comb begin
    dispatch_ready = '0;
    accept         = '0;
    nacc           = '0;
    free_slots     = (IDX_W+1)'(NUM_ROB) - count_reg + nret;
    dsp_ok         = en & ~rollback_en & ~halted_reg;
    for (int k = 0; k < WIDTH; k++) begin
      dispatch_ready[k] = dsp_ok && (free_slots > (IDX_W+1)'(k));
      if (dispatch_valid[k] && dispatch_ready[k] && (k == 0 || accept[k == 0 ? 0 : k-1])) begin
        accept[k] = 1'b1;
        nacc      = nacc + ONE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_reg   <= '0;
      tail_reg   <= '0;
      count_reg  <= '0;
      halted_reg <= 1'b0;
      for (int i = 0; i < NUM_ROB; i++) begin
        valid_reg[i]      <= 1'b0;
        complete_reg[i]   <= 1'b0;
        entry_halt_reg[i] <= 1'b0;
        t_idx_reg[i]      <= '0;
        told_idx_reg[i]   <= '0;
        dest_idx_reg[i]   <= '0;
      end
    end else if (en) begin
      // Later assignments win: complete < retire clear < rollback flush < dispatch write.
      for (int c = 0; c < CDB_WIDTH; c++) begin
        if (complete_valid[c] && valid_reg[cmp_idx[c]])
          complete_reg[cmp_idx[c]] <= 1'b1;
      end
      for (int j = 0; j < WIDTH; j++) begin
        if (retire_valid[j]) begin
          valid_reg[ret_ptr[j]]    <= 1'b0;
          complete_reg[ret_ptr[j]] <= 1'b0;
        end
      end
      if (rb_act) begin
        for (int i = 0; i < NUM_ROB; i++) begin
          if ((IDX_W'(i) - head_reg) > rb_off) begin
            valid_reg[i]    <= 1'b0;
            complete_reg[i] <= 1'b0;
          end
        end
      end
      for (int k = 0; k < WIDTH; k++) begin
        if (accept[k]) begin
          valid_reg[dsp_ptr[k]]      <= 1'b1;
          complete_reg[dsp_ptr[k]]   <= 1'b0;
          entry_halt_reg[dsp_ptr[k]] <= dispatch_halt[k];
          t_idx_reg[dsp_ptr[k]]      <= dispatch_T_idx[k*PR_W +: PR_W];
          told_idx_reg[dsp_ptr[k]]   <= dispatch_Told_idx[k*PR_W +: PR_W];
          dest_idx_reg[dsp_ptr[k]]   <= dispatch_dest_idx[k*AR_W +: AR_W];
        end
      end
      head_reg   <= head_reg + IDX_W'(nret);
      halted_reg <= halted_reg | halt_out;
      if (rb_act) begin
        tail_reg  <= rollback_idx + IDX_W'(1);
        count_reg <= {1'b0, rb_off} + ONE - nret;
      end else begin
        tail_reg  <= tail_reg + IDX_W'(nacc);
        count_reg <= count_reg + nacc - nret;
      end
    end
  end

endmodule

// File: doc/rob_multiway.md
# rob_multiway

Parametrised N-way reorder buffer for the R10000-style out-of-order core, sitting between decode/rename (dispatch), the CDB (complete), and the architectural map table / free list (retire). It accepts up to WIDTH in-order dispatches per cycle, marks entries complete from up to CDB_WIDTH broadcasts, and retires up to WIDTH consecutive completed head entries per cycle. An occupancy counter removes head==tail ambiguity. Branch rollback restores the tail in a single cycle, with no recovery stall state.

## Interface
- NUM_ROB, 32: entry count; must be a power of 2.
- WIDTH, 2: dispatch and retire lanes; 1 ≤ WIDTH ≤ NUM_ROB.
- CDB_WIDTH, 2: completion ports.
- PR_W, 6: physical register index width.
- AR_W, 5: architectural register index width.
- IDX_W, $clog2(NUM_ROB): derived ROB index width.
- clock  in  1  single clock; every register updates on posedge.
- reset  in  1  synchronous, active-high; takes priority over en.
- en  in  1  global advance; when low, all state holds.
- dispatch_valid  in  WIDTH  per-lane dispatch request; must be lane-0 contiguous (a thermometer mask).
- dispatch_T_idx / dispatch_Told_idx  in  WIDTH*PR_W  new and previous physical register per lane.
- dispatch_dest_idx  in  WIDTH*AR_W  architectural destination per lane.
- dispatch_halt  in  WIDTH  lane carries a halt instruction.
- dispatch_ready  out  WIDTH  bit k high when free slots > k and dispatch is legal this cycle.
- dispatch_ROB_idx  out  WIDTH*IDX_W  lane k = (tail+k) mod NUM_ROB.
- complete_valid  in  CDB_WIDTH  completion strobes.
- complete_ROB_idx  in  CDB_WIDTH*IDX_W  completing entries.
- rollback_en  in  1  mispredict on entry rollback_idx.
- rollback_idx  in  IDX_W  index of the mispredicted branch; that entry survives.
- retire_valid  out  WIDTH  per-lane retire, thermometer from lane 0.
- retire_T_idx / retire_Told_idx  out  WIDTH*PR_W  to the arch map table and free list.
- retire_dest_idx  out  WIDTH*AR_W  to the arch map table.
- halt_out  out  1  a halt entry retires this cycle.
- count  out  IDX_W+1  current occupancy.

## Operation
- State:
  - head and tail: IDX_W bits each, wrapping mod NUM_ROB.
  - count: 0..NUM_ROB.
  - halted flag.
  - Per entry: valid, complete, halt, T_idx, Told_idx, dest_idx.
- Dispatch:
  - Lane k is accepted iff dispatch_valid[k] & dispatch_ready[k].
  - An accepted lane writes entry tail+k with valid=1, complete=0 and its payload.
  - tail advances by the number of accepted lanes.
  - dispatch_ready is forced 0 when en=0, rollback_en=1, or halted=1.
  - Free slots = NUM_ROB − count + nret, where nret is the number of retires this cycle. Same-cycle retire frees space.
- Complete:
  - Each strobe sets complete on its entry if that entry is valid; strobes to invalid entries are ignored.
  - Duplicate strobes to one index are harmless.
  - If a strobe hits the slot being dispatched in the same cycle, dispatch wins and complete=0.
- Retire:
  - Lane j is valid iff entry head+j is valid & complete, all lower lanes are valid, en=1, and halted=0.
  - After a halt entry retires on lane j, lanes above j are masked.
  - On a rollback cycle, lanes beyond rollback_idx are masked.
  - Retired entries are cleared to valid=0, and head advances by nret.
  - halt_out = OR over valid lanes of that lane's halt bit. It sets halted, which blocks all further dispatch and retire until reset.
- Rollback:
  - Acts only if entry rollback_idx is valid.
  - Entries strictly younger than rollback_idx, up to tail−1, are cleared, wrap handled mod NUM_ROB.
  - tail becomes rollback_idx+1.
  - count becomes ((rollback_idx − head) mod NUM_ROB) + 1 − nret.
  - Branch completion on that cycle is still applied.
- count_next = count + naccepted − nret on non-rollback cycles. The block never over- or underflows.

## Timing
- Reset values:
  - head=0, tail=0, count=0, halted=0; all entry fields 0.
  - Outputs: retire_valid=0, halt_out=0, count=0, dispatch_ROB_idx lane k = k.
  - dispatch_ready=all 1 if en=1, else 0.
- All outputs are combinational from registered state plus the current-cycle inputs (dispatch_ready also depends on nret and rollback_en).
- Dispatch in cycle t makes the entry visible in cycle t+1.
- Completion in cycle t makes the entry retire-eligible in cycle t+1 at the earliest.
- Minimum dispatch-to-retire latency is 2 cycles.
- Rollback takes effect at the next edge, and new dispatch is accepted from cycle t+1.
- Boundary cases:
  - Full (count=NUM_ROB) with one retire: dispatch_ready[0]=1.
  - Empty: retire_valid=0.
  - Wrap: indices NUM_ROB−1 → 0 are seamless within one multi-lane transfer.
- Reset asserted mid-operation returns the block to reset values at the next edge, regardless of en, rollback_en or halted.

## Test plan
- Reset, then dispatch 2 lanes/cycle for 16 cycles with no completes (NUM_ROB=32, WIDTH=2) -> count=32, dispatch_ready=00, dispatch_ROB_idx lanes = 0,1.
- Fill to full, complete entries 0 and 1, then present dispatch_valid=01 -> retire_valid=11, head=2, the dispatch is accepted into entry 0, count=31.
- Complete entries in order 3,1,0 (entry 2 incomplete) -> the next cycle retires entries 0,1 only; after 2 completes, entries 2,3 retire together.
- With head=28 and tail=4 (8 valid, wrapped), rollback_idx=30 -> tail=31, count=3, entries 31,0..3 invalid, dispatch_ready=0 that cycle.
- Entries 5 (halt) and 6 both complete at head=5 -> retire_valid=01, halt_out=1; afterwards retire_valid=0 and dispatch_ready=0 until reset.
- Pulse reset while count=10 with rollback_en=1 -> next cycle count=0, head=tail=0, halted=0, retire_valid=0.
